// File: rtl/hybridcache_pkg.sv
// hybridcache_pkg -- shared definitions for the hybrid cache blocks.
//   * default geometry constants used as parameter defaults
//   * linefill FSM state encoding
package hybridcache_pkg;

   localparam int DEF_DATABITS    = 32;  // cache word / memory beat width
   localparam int DEF_ADDRBITS    = 5;   // data store word-address width
   localparam int DEF_LINEBITS    = 2;   // log2(words per line)
   localparam int DEF_MEMADDRBITS = 32;  // memory word-address width

   typedef enum logic [1:0] {
      LF_IDLE = 2'd0,
      LF_REQ  = 2'd1,
      LF_FILL = 2'd2,
      LF_DONE = 2'd3
   } lf_state_t;

endpackage

// File: rtl/hybrid_linefill.sv
// hybrid_linefill -- fetches one cache line from memory as a burst and
// writes it into the mydpram data store that sits beside it.
//
// Ports
//   clk, reset          sole clock, synchronous active-high reset
//   fill_req            start a fill (sampled only while idle)
//   fill_slot           destination line index in the data store
//   fill_memaddr        word address of the missing word
//   fill_busy           high whenever a fill is in progress (not idle)
//   fill_done           one-cycle pulse after the last word is written
//   mem_rdreq/rdaddr    burst read request, held until mem_rdack
//   mem_rdack           request accepted when high together with mem_rdreq
//   mem_rdvalid/rddata  one returned beat per cycle where valid is high
//   ram_wraddr/we/in    write port of the data store
//
// Build option
//   CRITICAL_WORD_FIRST_EN  when defined, the burst starts at the missing
//                           word and the line offset wraps through the line;
//                           otherwise the burst starts at the line base.
module hybrid_linefill
   import hybridcache_pkg::*;
#(
   parameter int DATABITS    = DEF_DATABITS,
   parameter int ADDRBITS    = DEF_ADDRBITS,
   parameter int LINEBITS    = DEF_LINEBITS,
   parameter int MEMADDRBITS = DEF_MEMADDRBITS
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fill_req,
   input  logic [ADDRBITS-LINEBITS-1:0] fill_slot,
   input  logic [MEMADDRBITS-1:0]   fill_memaddr,
   output logic                     fill_busy,
   output logic                     fill_done,
   output logic                     mem_rdreq,
   output logic [MEMADDRBITS-1:0]   mem_rdaddr,
   input  logic                     mem_rdack,
   input  logic                     mem_rdvalid,
   input  logic [DATABITS-1:0]      mem_rddata,
   output logic [ADDRBITS-1:0]      ram_wraddr,
   output logic                     ram_we,
   output logic [DATABITS-1:0]      ram_in
);

   localparam int SLOTBITS = ADDRBITS - LINEBITS;

   lf_state_t               state, state_nx;
   logic [SLOTBITS-1:0]     slot_q;
   logic [MEMADDRBITS-1:0]  addr_q;
   logic [MEMADDRBITS-1:0]  addr_in;
   logic [LINEBITS-1:0]     cnt_q;
   logic [LINEBITS-1:0]     off;
   logic                    last_beat;

   // The burst start address is decided at latch time, so the rest of the
   // block is identical in both builds: without critical-word-first the low
   // bits are zero and the offset sequence naturally starts at 0.
`ifdef CRITICAL_WORD_FIRST_EN
   assign addr_in = fill_memaddr;
`else
   assign addr_in = fill_memaddr & {{(MEMADDRBITS-LINEBITS){1'b1}}, {LINEBITS{1'b0}}};
`endif

   assign mem_rdaddr = addr_q;

   // LINEBITS-wide add: the offset wraps inside the line and can never
   // carry into the slot bits.
   assign off        = addr_q[LINEBITS-1:0] + cnt_q;
   assign last_beat  = (cnt_q == {LINEBITS{1'b1}});
   assign ram_wraddr = {slot_q, off};
   assign ram_in     = mem_rddata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= LF_IDLE;
         slot_q <= '0;
         addr_q <= '0;
         cnt_q  <= '0;
      end else begin
         state <= state_nx;
         if (state == LF_IDLE && fill_req) begin
            slot_q <= fill_slot;
            addr_q <= addr_in;
         end
         if (state == LF_REQ && mem_rdack)
            cnt_q <= '0;
         else if (state == LF_FILL && mem_rdvalid)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_nx  = state;
      fill_busy = 1'b1;
      fill_done = 1'b0;
      mem_rdreq = 1'b0;
      ram_we    = 1'b0;
      case (state)
         LF_IDLE: begin
            fill_busy = 1'b0;
            if (fill_req) state_nx = LF_REQ;
         end
         LF_REQ: begin
            mem_rdreq = 1'b1;
            if (mem_rdack) state_nx = LF_FILL;
         end
         LF_FILL: begin
            // Beats only reach the store here; gaps of any length just wait.
            ram_we = mem_rdvalid;
            if (mem_rdvalid && last_beat) state_nx = LF_DONE;
         end
         LF_DONE: begin
            // fill_req is ignored here, forcing one idle cycle between fills.
            fill_done = 1'b1;
            state_nx  = LF_IDLE;
         end
         default: state_nx = LF_IDLE;
      endcase
   end

endmodule

// File: tb/tb_hybrid_linefill.sv
module tb_hybrid_linefill;

   localparam int DB = 32, AB = 5, LB = 2, MB = 32;
   localparam int SB = AB - LB;
   localparam int WPL = 1 << LB;

   logic           clk = 1'b0;
   logic           reset;
   logic           fill_req;
   logic [SB-1:0]  fill_slot;
   logic [MB-1:0]  fill_memaddr;
   logic           fill_busy, fill_done;
   logic           mem_rdreq;
   logic [MB-1:0]  mem_rdaddr;
   logic           mem_rdack, mem_rdvalid;
   logic [DB-1:0]  mem_rddata;
   logic [AB-1:0]  ram_wraddr;
   logic           ram_we;
   logic [DB-1:0]  ram_in;

   hybrid_linefill #(.DATABITS(DB), .ADDRBITS(AB), .LINEBITS(LB), .MEMADDRBITS(MB)) dut (
      .clk(clk), .reset(reset), .fill_req(fill_req), .fill_slot(fill_slot),
      .fill_memaddr(fill_memaddr), .fill_busy(fill_busy), .fill_done(fill_done),
      .mem_rdreq(mem_rdreq), .mem_rdaddr(mem_rdaddr), .mem_rdack(mem_rdack),
      .mem_rdvalid(mem_rdvalid), .mem_rddata(mem_rddata), .ram_wraddr(ram_wraddr),
      .ram_we(ram_we), .ram_in(ram_in)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: line geometry from plain arithmetic.
   function automatic logic [MB-1:0] m_rdaddr(input logic [MB-1:0] ma);
`ifdef CRITICAL_WORD_FIRST_EN
      return ma;
`else
      return ma - (ma % WPL);
`endif
   endfunction

   function automatic logic [AB-1:0] m_addr(input logic [SB-1:0] slot, input logic [MB-1:0] ma, input int i);
      int start;
`ifdef CRITICAL_WORD_FIRST_EN
      start = int'(ma % WPL);
`else
      start = 0;
`endif
      return AB'(int'(slot) * WPL + (start + i) % WPL);
   endfunction

   logic [AB-1:0] got_addr[WPL];
   logic [DB-1:0] got_data[WPL];
   int            got_n;

   // One full fill: ack after ack_dly cycles (junk beats meanwhile), gap idle
   // cycles before each beat, then DONE and back to IDLE.
   task automatic do_fill(input logic [SB-1:0] slot, input logic [MB-1:0] ma,
                          input int ack_dly, input int gap, input logic [DB-1:0] dbase,
                          input logic [MB-1:0] exp_rdaddr);
      got_n = 0;
      @(negedge clk);
      fill_req = 1'b1; fill_slot = slot; fill_memaddr = ma;
      mem_rdack = 1'b0; mem_rdvalid = 1'b0;
      #1 chk("idle_busy", fill_busy, 0);
      for (int c = 0; c < ack_dly; c++) begin
         @(negedge clk);
         fill_req = 1'b0; fill_slot = SB'($urandom); fill_memaddr = $urandom;
         mem_rdack = 1'b0; mem_rdvalid = 1'b1; mem_rddata = $urandom;
         #1;
         chk("req_hold", mem_rdreq, 1);
         chk("req_addr", mem_rdaddr, exp_rdaddr);
         chk("req_no_we", ram_we, 0);
      end
      @(negedge clk);
      fill_req = 1'b0; fill_slot = SB'($urandom); fill_memaddr = $urandom;
      mem_rdack = 1'b1; mem_rdvalid = 1'b0;
      #1;
      chk("ack_rdreq", mem_rdreq, 1);
      chk("ack_addr", mem_rdaddr, exp_rdaddr);
      for (int b = 0; b < WPL; b++) begin
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            mem_rdack = 1'b0; mem_rdvalid = 1'b0;
            #1;
            chk("gap_busy", fill_busy, 1);
            chk("gap_no_we", ram_we, 0);
            chk("gap_no_req", mem_rdreq, 0);
         end
         @(negedge clk);
         mem_rdack = 1'b0; mem_rdvalid = 1'b1; mem_rddata = dbase + DB'(b);
         #1;
         chk("beat_we", ram_we, 1);
         chk("beat_data", ram_in, dbase + DB'(b));
         chk("beat_nodone", fill_done, 0);
         got_addr[b] = ram_wraddr; got_data[b] = ram_in; got_n++;
      end
      @(negedge clk);
      mem_rdvalid = 1'b1; mem_rddata = $urandom;
      #1;
      chk("done_pulse", fill_done, 1);
      chk("done_no_we", ram_we, 0);
      chk("done_busy", fill_busy, 1);
      @(negedge clk);
      #1;
      chk("done_clear", fill_done, 0);
      chk("back_idle", fill_busy, 0);
      chk("idle_no_we", ram_we, 0);
      mem_rdvalid = 1'b0;
   endtask

   typedef struct {
      logic [SB-1:0] slot;
      logic [MB-1:0] ma;
      int            ack_dly;
      int            gap;
      logic [MB-1:0] exp_rdaddr;
      logic [AB-1:0] exp_a[WPL];
   } vec_t;

   vec_t tbl[5];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DB-1:0] dbase;
      int done_cyc, req2_cyc, ndone, nwe;
      logic prev_req;

`ifdef CRITICAL_WORD_FIRST_EN
      tbl[0] = '{slot:2, ma:32'h100,      ack_dly:0, gap:0, exp_rdaddr:32'h100,      exp_a:'{8,9,10,11}};
      tbl[1] = '{slot:2, ma:32'h102,      ack_dly:0, gap:0, exp_rdaddr:32'h102,      exp_a:'{10,11,8,9}};
      tbl[2] = '{slot:7, ma:32'h3F,       ack_dly:1, gap:1, exp_rdaddr:32'h3F,       exp_a:'{31,28,29,30}};
      tbl[3] = '{slot:0, ma:32'hFFFFFFFD, ack_dly:0, gap:0, exp_rdaddr:32'hFFFFFFFD, exp_a:'{1,2,3,0}};
      tbl[4] = '{slot:5, ma:32'h1001,     ack_dly:5, gap:3, exp_rdaddr:32'h1001,     exp_a:'{21,22,23,20}};
`else
      tbl[0] = '{slot:2, ma:32'h100,      ack_dly:0, gap:0, exp_rdaddr:32'h100,      exp_a:'{8,9,10,11}};
      tbl[1] = '{slot:2, ma:32'h102,      ack_dly:0, gap:0, exp_rdaddr:32'h100,      exp_a:'{8,9,10,11}};
      tbl[2] = '{slot:7, ma:32'h3F,       ack_dly:1, gap:1, exp_rdaddr:32'h3C,       exp_a:'{28,29,30,31}};
      tbl[3] = '{slot:0, ma:32'hFFFFFFFD, ack_dly:0, gap:0, exp_rdaddr:32'hFFFFFFFC, exp_a:'{0,1,2,3}};
      tbl[4] = '{slot:5, ma:32'h1001,     ack_dly:5, gap:3, exp_rdaddr:32'h1000,     exp_a:'{20,21,22,23}};
`endif

      // Reset state
      reset = 1'b1; fill_req = 1'b0; fill_slot = '0; fill_memaddr = '0;
      mem_rdack = 1'b0; mem_rdvalid = 1'b0; mem_rddata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_rdreq", mem_rdreq, 0);
      chk("rst_busy", fill_busy, 0);
      chk("rst_done", fill_done, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_wraddr", ram_wraddr, 0);
      chk("rst_rdaddr", mem_rdaddr, 0);

      // Directed table
      for (int i = 0; i < 5; i++) begin
         dbase = 32'hA0000000 + DB'(i << 8);
         do_fill(tbl[i].slot, tbl[i].ma, tbl[i].ack_dly, tbl[i].gap, dbase, tbl[i].exp_rdaddr);
         chk("tbl_nbeats", got_n, WPL);
         for (int k = 0; k < WPL; k++) begin
            chk($sformatf("tbl%0d_addr%0d", i, k), got_addr[k], tbl[i].exp_a[k]);
            chk($sformatf("tbl%0d_data%0d", i, k), got_data[k], dbase + DB'(k));
         end
      end

      // Reset after beat 2 aborts the fill
      @(negedge clk);
      fill_req = 1'b1; fill_slot = 3'd3; fill_memaddr = 32'h40;
      @(negedge clk);
      fill_req = 1'b0; mem_rdack = 1'b1;
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         mem_rdack = 1'b0; mem_rdvalid = 1'b1; mem_rddata = 32'h5A5A0000 + DB'(b);
         #1 chk("abort_beat_we", ram_we, 1);
      end
      @(negedge clk);
      mem_rdvalid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; mem_rdvalid = 1'b1; mem_rddata = 32'hDEAD;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("abort_idle", fill_busy, 0);
         chk("abort_nodone", fill_done, 0);
         chk("abort_no_we", ram_we, 0);
         chk("abort_rdreq", mem_rdreq, 0);
         chk("abort_wraddr", ram_wraddr, 0);
         chk("abort_rdaddr", mem_rdaddr, 0);
         @(negedge clk);
      end
      mem_rdvalid = 1'b0;

      // fill_req held high: next request two cycles after fill_done
      done_cyc = -1; req2_cyc = -1; ndone = 0; nwe = 0; prev_req = 1'b0;
      fill_req = 1'b1; fill_slot = 3'd1; fill_memaddr = 32'h200;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         mem_rdack = mem_rdreq; mem_rdvalid = 1'b1; mem_rddata = DB'(c);
         if (req2_cyc >= 0) fill_req = 1'b0;
         #1;
         if (fill_done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (ram_we) nwe++;
         if (mem_rdreq && !prev_req && done_cyc >= 0 && req2_cyc < 0) req2_cyc = c;
         prev_req = mem_rdreq;
      end
      mem_rdvalid = 1'b0; mem_rdack = 1'b0; fill_req = 1'b0;
      chk("held_req_gap", req2_cyc - done_cyc, 2);
      chk("held_ndone", ndone, 2);
      chk("held_nwe", nwe, 2 * WPL);
      #1 chk("held_idle", fill_busy, 0);

      // Randomized fills against the model
      for (int r = 0; r < 30; r++) begin
         logic [SB-1:0] s;
         logic [MB-1:0] ma;
         s = SB'($urandom);
         ma = $urandom;
         dbase = $urandom;
         do_fill(s, ma, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), dbase, m_rdaddr(ma));
         chk("rnd_nbeats", got_n, WPL);
         for (int k = 0; k < WPL; k++) begin
            chk($sformatf("rnd%0d_addr%0d", r, k), got_addr[k], m_addr(s, ma, k));
            chk($sformatf("rnd%0d_data%0d", r, k), got_data[k], dbase + DB'(k));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
